// File: rtl/ddr3_responder_pkg.sv
// Shared definitions for the DDR3 device-side responder: command codes,
// burst engine state encoding and error flag bit positions.
package ddr3_responder_pkg;

  localparam logic [3:0] CMD_MRS = 4'b0000;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD_BEATS,
    ST_WR_BEATS
  } engine_state_e;

  localparam int ERR_CLOSED_BANK = 0;
  localparam int ERR_ACT_OPEN    = 1;
  localparam int ERR_REF_OPEN    = 2;
  localparam int ERR_BUSY        = 3;
  localparam int NUM_ERR         = 4;

  // A deselected device or a low CKE sees only NOPs.
  function automatic logic [3:0] decode_cmd(input logic ck_en, input logic cs_n,
                                            input logic ras_n, input logic cas_n,
                                            input logic we_n);
    if (!ck_en || cs_n) return CMD_NOP;
    return {cs_n, ras_n, cas_n, we_n};
  endfunction

endpackage

// File: rtl/ddr3_responder_burst_engine.sv
// Burst sequencer: latency countdown, beat counter, sequential column wrap
// and read strobe / output-enable generation.
module ddr3_responder_burst_engine
  import ddr3_responder_pkg::*;
#(
  parameter int CL           = 5,
  parameter int CWL          = 5,
  parameter int BURST_LENGTH = 8,
  parameter int BASE_BITS    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 start_rd,
  input  logic [BASE_BITS-1:0] start_base,
  input  logic [2:0]           start_col,
  output logic                 idle,
  output logic                 beat_valid,
  output logic                 beat_rd,
  output logic [BASE_BITS+2:0] beat_index,
  output logic                 dq_oe,
  output logic                 dqs_o
);

  localparam int LAT_MAX = (CL > CWL) ? CL : CWL;
  localparam int WAIT_W  = $clog2(LAT_MAX + 1);
  localparam int BEAT_W  = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;

  engine_state_e        state;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [BEAT_W-1:0]    beat_cnt;
  logic                 rd_q;
  logic [BASE_BITS-1:0] base_q;
  logic [2:0]           col_q;

  logic [BEAT_W-1:0]    beat_k;
  logic                 last_beat;
  logic [2:0]           beat_col;

  // The final countdown edge already carries beat 0, so WAIT doubles as a beat state.
  assign beat_k     = (state == ST_WAIT) ? '0 : beat_cnt;
  assign last_beat  = (beat_k == BEAT_W'(BURST_LENGTH - 1));
  assign beat_valid = ((state == ST_WAIT) && (wait_cnt == '0)) ||
                      (state == ST_RD_BEATS) || (state == ST_WR_BEATS);
  assign beat_rd    = rd_q;
  assign beat_col   = col_q + 3'(beat_k);
  assign beat_index = {base_q, beat_col};
  assign idle       = (state == ST_IDLE);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values and the ordering of statements does not matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      beat_cnt <= '0;
      rd_q     <= 1'b0;
      base_q   <= '0;
      col_q    <= '0;
      dq_oe    <= 1'b0;
      dqs_o    <= 1'b0;
    end else begin
      dq_oe <= beat_valid && rd_q;
      dqs_o <= beat_valid && rd_q && !beat_k[0];
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_WAIT;
            rd_q     <= start_rd;
            base_q   <= start_base;
            col_q    <= start_col;
            wait_cnt <= start_rd ? WAIT_W'(CL - 1) : WAIT_W'(CWL - 1);
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            beat_cnt <= BEAT_W'(1);
            if (last_beat)  state <= ST_IDLE;
            else if (rd_q)  state <= ST_RD_BEATS;
            else            state <= ST_WR_BEATS;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RD_BEATS, ST_WR_BEATS: begin
          if (last_beat) state <= ST_IDLE;
          else           beat_cnt <= beat_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ddr3_memory_responder.sv
// DDR3 device-side responder: command decode, per-bank open-row table and a
// 256-word array. Define DDR3_RESPONDER_ERR_CHECK_EN to enable sticky err_flags.
module ddr3_memory_responder
  import ddr3_responder_pkg::*;
#(
  parameter int ADDRESS_BITWIDTH      = 15,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int DQ_BITWIDTH           = 16,
  parameter int CL                    = 5,
  parameter int CWL                   = 5,
  parameter int BURST_LENGTH          = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ck_en,
  input  logic                             cs_n,
  input  logic                             ras_n,
  input  logic                             cas_n,
  input  logic                             we_n,
  input  logic [BANK_ADDRESS_BITWIDTH-1:0] bank_address,
  input  logic [ADDRESS_BITWIDTH-1:0]      address,
  input  logic [DQ_BITWIDTH-1:0]           dq_i,
  input  logic [1:0]                       dm_i,
  output logic [DQ_BITWIDTH-1:0]           dq_o,
  output logic                             dq_oe,
  output logic                             dqs_o,
  output logic [NUM_ERR-1:0]               err_flags,
  output logic [15:0]                      refresh_count
);

  localparam int NUM_BANKS = 1 << BANK_ADDRESS_BITWIDTH;
  localparam int BASE_BITS = BANK_ADDRESS_BITWIDTH + 2;
  localparam int INDEX_W   = BASE_BITS + 3;
  localparam int DEPTH     = 1 << INDEX_W;
  localparam int LANE_W    = DQ_BITWIDTH / 2;

  logic [3:0]             cmd;
  logic                   is_col;
  logic                   sel_open;
  logic                   accept;
  logic [NUM_BANKS-1:0]   bank_open;
  logic [1:0]             bank_row [NUM_BANKS];

  logic                   idle;
  logic                   beat_valid;
  logic                   beat_rd;
  logic [INDEX_W-1:0]     beat_index;

  logic [DQ_BITWIDTH-1:0] mem [DEPTH];

  // Row bits above 1, column bits above 2 and A10 on column commands alias away.
  logic unused_addr;
  assign unused_addr = ^{address[ADDRESS_BITWIDTH-1:11], address[9:3]};

  assign cmd      = decode_cmd(ck_en, cs_n, ras_n, cas_n, we_n);
  assign is_col   = (cmd == CMD_RD) || (cmd == CMD_WR);
  assign sel_open = bank_open[bank_address];
  assign accept   = is_col && sel_open && idle;

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_open <= '0;
      for (int b = 0; b < NUM_BANKS; b++) bank_row[b] <= '0;
    end else begin
      case (cmd)
        CMD_ACT: begin
          bank_open[bank_address] <= 1'b1;
          bank_row[bank_address]  <= address[1:0];
        end
        CMD_PRE: begin
          if (address[10]) bank_open <= '0;
          else             bank_open[bank_address] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                          refresh_count <= '0;
    else if ((cmd == CMD_REF) && (refresh_count != 16'hFFFF)) refresh_count <= refresh_count + 16'd1;
  end

  ddr3_responder_burst_engine #(
    .CL          (CL),
    .CWL         (CWL),
    .BURST_LENGTH(BURST_LENGTH),
    .BASE_BITS   (BASE_BITS)
  ) u_engine (
    .clk       (clk),
    .reset     (reset),
    .start     (accept),
    .start_rd  (cmd == CMD_RD),
    .start_base({bank_address, bank_row[bank_address]}),
    .start_col (address[2:0]),
    .idle      (idle),
    .beat_valid(beat_valid),
    .beat_rd   (beat_rd),
    .beat_index(beat_index),
    .dq_oe     (dq_oe),
    .dqs_o     (dqs_o)
  );

  // NOTE: the array has no reset branch so it maps onto block RAM; reset only
  // gates the write enable so an aborted burst stops writing immediately.
  always_ff @(posedge clk) begin
    if (!reset && beat_valid && !beat_rd) begin
      if (!dm_i[0]) mem[beat_index][LANE_W-1:0]           <= dq_i[LANE_W-1:0];
      if (!dm_i[1]) mem[beat_index][DQ_BITWIDTH-1:LANE_W] <= dq_i[DQ_BITWIDTH-1:LANE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                      dq_o <= '0;
    else if (beat_valid && beat_rd) dq_o <= mem[beat_index];
    else                            dq_o <= '0;
  end

`ifdef DDR3_RESPONDER_ERR_CHECK_EN
  logic [NUM_ERR-1:0] err_q;
  logic               any_open;

  assign any_open  = |bank_open;
  assign err_flags = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      if (is_col && !sel_open)             err_q[ERR_CLOSED_BANK] <= 1'b1;
      if (is_col && !idle)                 err_q[ERR_BUSY]        <= 1'b1;
      if ((cmd == CMD_ACT) && sel_open)    err_q[ERR_ACT_OPEN]    <= 1'b1;
      if ((cmd == CMD_REF) && any_open)    err_q[ERR_REF_OPEN]    <= 1'b1;
    end
  end
`else
  assign err_flags = '0;
`endif

endmodule

// File: tb/tb_ddr3_memory_responder.sv
// Scoreboard bench for ddr3_memory_responder: expected read beats are queued
// at command issue and matched by a monitor sampling 2 time units after each edge.
module tb_ddr3_memory_responder;

  localparam int CL  = 5;
  localparam int CWL = 5;
  localparam int BL  = 8;

  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_NOP = 4'b0111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ck_en = 1'b1;
  logic        cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [2:0]  bank_address = '0;
  logic [14:0] address = '0;
  logic [15:0] dq_i = '0;
  logic [1:0]  dm_i = 2'b11;
  logic [15:0] dq_o;
  logic        dq_oe;
  logic        dqs_o;
  logic [3:0]  err_flags;
  logic [15:0] refresh_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic        dqs;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] model_mem [256];
  logic [1:0]  model_row [8];

  ddr3_memory_responder #(
    .ADDRESS_BITWIDTH(15), .BANK_ADDRESS_BITWIDTH(3), .DQ_BITWIDTH(16),
    .CL(CL), .CWL(CWL), .BURST_LENGTH(BL)
  ) dut (
    .clk(clk), .reset(reset), .ck_en(ck_en), .cs_n(cs_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .bank_address(bank_address), .address(address),
    .dq_i(dq_i), .dm_i(dm_i), .dq_o(dq_o), .dq_oe(dq_oe), .dqs_o(dqs_o),
    .err_flags(err_flags), .refresh_count(refresh_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] xerr(input logic [3:0] e);
`ifdef DDR3_RESPONDER_ERR_CHECK_EN
    return e;
`else
    return e & 4'b0000;
`endif
  endfunction

  // Beat monitor: every driven beat must match the queue head in cycle, data and strobe.
  initial begin
    forever begin : mon
      beat_t b;
      @(posedge clk);
      #2;
      if (dq_oe === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat cyc %0d dq_o %h, required no beat", cyc, dq_o);
        end else begin
          b = exp_q.pop_front();
          if (b.cyc !== cyc || dq_o !== b.data || dqs_o !== b.dqs) begin
            errors++;
            $display("FAIL read_beat got cyc %0d dq %h dqs %b, required cyc %0d dq %h dqs %b",
                     cyc, dq_o, dqs_o, b.cyc, b.data, b.dqs);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_beat no dq_oe at cyc %0d, required dq %h", cyc, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1);
  end

  // Commands are driven on the falling edge; caller is always at a falling edge.
  task automatic cmd(input logic [3:0] c, input logic [2:0] ba, input logic [14:0] a);
    {cs_n, ras_n, cas_n, we_n} = c;
    bank_address = ba;
    address      = a;
    @(negedge clk);
    {cs_n, ras_n, cas_n, we_n} = C_NOP;
  endtask

  task automatic act(input logic [2:0] ba, input logic [1:0] row);
    model_row[ba] = row;
    cmd(C_ACT, ba, {13'd0, row});
  endtask

  task automatic wr_burst(input logic [2:0] ba, input logic [2:0] col, input logic [15:0] first,
                          input logic [15:0] step, input logic [1:0] dm);
    logic [7:0]  idx;
    logic [15:0] d;
    cmd(C_WR, ba, {12'd0, col});
    repeat (CWL - 1) @(negedge clk);
    for (int k = 0; k < BL; k++) begin
      d    = first + step * 16'(k);
      dq_i = d;
      dm_i = dm;
      idx  = {ba, model_row[ba], 3'(col + 3'(k))};
      if (!dm[0]) model_mem[idx][7:0]  = d[7:0];
      if (!dm[1]) model_mem[idx][15:8] = d[15:8];
      @(negedge clk);
    end
    dq_i = '0;
    dm_i = 2'b11;
  endtask

  task automatic rd_burst(input logic [2:0] ba, input logic [2:0] col, input bit accepted);
    beat_t b;
    int    e0;
    e0 = cyc + 1;
    if (accepted) begin
      for (int k = 0; k < BL; k++) begin
        b.cyc  = e0 + CL + k;
        b.data = model_mem[{ba, model_row[ba], 3'(col + 3'(k))}];
        b.dqs  = (k % 2 == 0);
        exp_q.push_back(b);
      end
    end
    cmd(C_RD, ba, {12'd0, col});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (CL + BL + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (dq_oe !== 1'b0) begin errors++; $display("FAIL reset_dq_oe got %b required 0", dq_oe); end
    checks++; if (dq_o !== 16'h0) begin errors++; $display("FAIL reset_dq_o got %h required 0000", dq_o); end
    checks++; if (dqs_o !== 1'b0) begin errors++; $display("FAIL reset_dqs_o got %b required 0", dqs_o); end
    checks++; if (err_flags !== 4'b0) begin errors++; $display("FAIL reset_err got %b required 0000", err_flags); end
    checks++; if (refresh_count !== 16'h0) begin errors++; $display("FAIL reset_refresh got %h required 0000", refresh_count); end
  endtask

  task automatic test_write_read();
    act(3'd2, 2'd1);
    wr_burst(3'd2, 3'd0, 16'h0001, 16'h0001, 2'b00);
    rd_burst(3'd2, 3'd0, 1'b1);
    wait_drain();
    checks++;
    if (err_flags !== xerr(4'b0000)) begin
      errors++; $display("FAIL write_read_err got %b required %b", err_flags, xerr(4'b0000));
    end
  endtask

  task automatic test_wrap();
    rd_burst(3'd2, 3'd5, 1'b1);
    wait_drain();
    checks++;
    if (err_flags !== xerr(4'b0000)) begin
      errors++; $display("FAIL wrap_err got %b required %b", err_flags, xerr(4'b0000));
    end
  endtask

  task automatic test_byte_mask();
    act(3'd3, 2'd2);
    wr_burst(3'd3, 3'd0, 16'h1234, 16'h0000, 2'b00);
    wr_burst(3'd3, 3'd0, 16'hAAAA, 16'h0000, 2'b10);
    rd_burst(3'd3, 3'd0, 1'b1);
    wait_drain();
  endtask

  task automatic test_closed_bank_and_busy();
    rd_burst(3'd4, 3'd0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (err_flags !== xerr(4'b0001)) begin
      errors++; $display("FAIL closed_bank_err got %b required %b", err_flags, xerr(4'b0001));
    end
    rd_burst(3'd3, 3'd0, 1'b1);
    repeat (2) @(negedge clk);
    rd_burst(3'd3, 3'd4, 1'b0);
    wait_drain();
    checks++;
    if (err_flags !== xerr(4'b1001)) begin
      errors++; $display("FAIL busy_err got %b required %b", err_flags, xerr(4'b1001));
    end
  endtask

  task automatic test_refresh();
    act(3'd0, 2'd0);
    cmd(C_REF, 3'd0, 15'd0);
    checks++;
    if (refresh_count !== 16'd1) begin
      errors++; $display("FAIL ref_open_count got %0d required 1", refresh_count);
    end
    checks++;
    if (err_flags !== xerr(4'b1101)) begin
      errors++; $display("FAIL ref_open_err got %b required %b", err_flags, xerr(4'b1101));
    end
    cmd(C_PRE, 3'd0, 15'h0400);
    cmd(C_REF, 3'd0, 15'd0);
    checks++;
    if (refresh_count !== 16'd2) begin
      errors++; $display("FAIL ref_closed_count got %0d required 2", refresh_count);
    end
    checks++;
    if (err_flags !== xerr(4'b1101)) begin
      errors++; $display("FAIL ref_closed_err got %b required %b", err_flags, xerr(4'b1101));
    end
    act(3'd1, 2'd0);
    act(3'd1, 2'd1);
    checks++;
    if (err_flags !== xerr(4'b1111)) begin
      errors++; $display("FAIL act_open_err got %b required %b", err_flags, xerr(4'b1111));
    end
    cmd(C_PRE, 3'd0, 15'h0400);
  endtask

  task automatic test_back_to_back();
    act(3'd2, 2'd1);
    rd_burst(3'd2, 3'd0, 1'b1);
    repeat (CL + BL - 1) @(negedge clk);
    rd_burst(3'd2, 3'd5, 1'b1);
    repeat (2) @(negedge clk);
    act(3'd2, 2'd3);
    wait_drain();
  endtask

  task automatic test_reset_mid_burst();
    act(3'd2, 2'd1);
    rd_burst(3'd2, 3'd0, 1'b1);
    repeat (CL + 2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checks++; if (dq_oe !== 1'b0) begin errors++; $display("FAIL midreset_dq_oe got %b required 0", dq_oe); end
    checks++; if (dq_o !== 16'h0) begin errors++; $display("FAIL midreset_dq_o got %h required 0000", dq_o); end
    checks++; if (dqs_o !== 1'b0) begin errors++; $display("FAIL midreset_dqs_o got %b required 0", dqs_o); end
    checks++; if (err_flags !== 4'b0) begin errors++; $display("FAIL midreset_err got %b required 0000", err_flags); end
    checks++; if (refresh_count !== 16'h0) begin errors++; $display("FAIL midreset_refresh got %h required 0000", refresh_count); end
    reset = 1'b0;
    @(negedge clk);
    rd_burst(3'd2, 3'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (err_flags !== xerr(4'b0001)) begin
      errors++; $display("FAIL after_reset_err got %b required %b", err_flags, xerr(4'b0001));
    end
    wait_drain();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_wrap();
    test_byte_mask();
    test_closed_bank_and_busy();
    test_refresh();
    test_back_to_back();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
